// File: rtl/alarm_controller.sv
// Alarm clock controller: alarm time editing, arm/ring/snooze state machine,
// ring and snooze timers, and beep drive. All outputs are registered.
module alarm_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_seconds,
    input  logic [5:0] cur_h,
    input  logic [5:0] cur_m,
    input  logic [5:0] cur_s,
    input  logic       set_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_arm,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic [5:0] alarm_h,
    output logic [5:0] alarm_m,
    output logic       field_sel,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer,
    output logic [1:0] snooze_cnt
);

    localparam int unsigned RING_SECS   = 60;
    localparam int unsigned SNOOZE_SECS = 300;
    localparam int unsigned MAX_SNOOZE  = 3;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic       r_sec_q, r_sel_q, r_inc_q, r_dec_q, r_arm_q, r_snz_q, r_stop_q;
    logic       w_sec_edge, w_sel_p, w_inc_p, w_dec_p, w_arm_p, w_snz_p, w_stop_p;

    logic [5:0] r_alarm_h, r_alarm_m;
    logic       r_field_sel;
    logic [5:0] r_ring_timer;
    logic [8:0] r_snooze_timer;
    logic       r_phase;
    logic [1:0] r_snooze_cnt;
    logic       r_armed, r_ringing, r_snoozing, r_buzzer;

    logic       w_time_match;
    logic       w_ring_start, w_ring_tick, w_snooze_start, w_snooze_tick, w_clear_cnt;
    logic       w_edit_inc, w_edit_dec;

    // Sample the seconds clock and buttons once per clk for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_q  <= 1'b0;
            r_sel_q  <= 1'b0;
            r_inc_q  <= 1'b0;
            r_dec_q  <= 1'b0;
            r_arm_q  <= 1'b0;
            r_snz_q  <= 1'b0;
            r_stop_q <= 1'b0;
        end else begin
            r_sec_q  <= clk_seconds;
            r_sel_q  <= btn_sel;
            r_inc_q  <= btn_inc;
            r_dec_q  <= btn_dec;
            r_arm_q  <= btn_arm;
            r_snz_q  <= btn_snooze;
            r_stop_q <= btn_stop;
        end
    end

    assign w_sec_edge = clk_seconds & ~r_sec_q;
    assign w_sel_p    = btn_sel     & ~r_sel_q;
    assign w_inc_p    = btn_inc     & ~r_inc_q;
    assign w_dec_p    = btn_dec     & ~r_dec_q;
    assign w_arm_p    = btn_arm     & ~r_arm_q;
    assign w_snz_p    = btn_snooze  & ~r_snz_q;
    assign w_stop_p   = btn_stop    & ~r_stop_q;

    assign w_time_match = (cur_h == r_alarm_h) && (cur_m == r_alarm_m) && (cur_s == 6'd0);

    // Next-state decode with priority arm > stop > snooze > seconds tick
    always_comb begin
        w_next_state   = r_state;
        w_ring_start   = 1'b0;
        w_ring_tick    = 1'b0;
        w_snooze_start = 1'b0;
        w_snooze_tick  = 1'b0;
        w_clear_cnt    = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_arm_p) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_arm_p) begin
                    w_next_state = ST_OFF;
                end else if (w_sec_edge && !set_mode && w_time_match) begin
                    w_next_state = ST_RINGING;
                    w_ring_start = 1'b1;
                end
            end
            ST_RINGING: begin
                if (w_arm_p) begin
                    w_next_state = ST_OFF;
                    w_clear_cnt  = 1'b1;
                end else if (w_stop_p) begin
                    w_next_state = ST_ARMED;
                    w_clear_cnt  = 1'b1;
                end else if (w_snz_p && (r_snooze_cnt < 2'(MAX_SNOOZE))) begin
                    w_next_state   = ST_SNOOZE;
                    w_snooze_start = 1'b1;
                end else if (w_sec_edge) begin
                    w_ring_tick = 1'b1;
                    if (r_ring_timer == 6'(RING_SECS - 1)) begin
                        w_next_state = ST_ARMED;
                        w_clear_cnt  = 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (w_arm_p) begin
                    w_next_state = ST_OFF;
                    w_clear_cnt  = 1'b1;
                end else if (w_stop_p) begin
                    w_next_state = ST_ARMED;
                    w_clear_cnt  = 1'b1;
                end else if (w_sec_edge) begin
                    w_snooze_tick = 1'b1;
                    if (r_snooze_timer <= 9'd1) begin
                        w_next_state = ST_RINGING;
                        w_ring_start = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_OFF;
        endcase
    end

    // State register, timers, beep phase and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_OFF;
            r_ring_timer   <= 6'd0;
            r_snooze_timer <= 9'd0;
            r_phase        <= 1'b0;
            r_snooze_cnt   <= 2'd0;
            r_armed        <= 1'b0;
            r_ringing      <= 1'b0;
            r_snoozing     <= 1'b0;
            r_buzzer       <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_armed    <= (w_next_state != ST_OFF);
            r_ringing  <= (w_next_state == ST_RINGING);
            r_snoozing <= (w_next_state == ST_SNOOZE);

            if (w_ring_start) begin
                r_ring_timer <= 6'd0;
                r_phase      <= 1'b1;
                r_buzzer     <= 1'b1;
            end else if (w_ring_tick) begin
                r_ring_timer <= r_ring_timer + 6'd1;
                r_phase      <= ~r_phase;
                r_buzzer     <= (w_next_state == ST_RINGING) & ~r_phase;
            end else begin
                r_buzzer     <= (w_next_state == ST_RINGING) & r_phase;
            end

            if (w_snooze_start) begin
                r_snooze_timer <= 9'(SNOOZE_SECS);
            end else if (w_snooze_tick) begin
                r_snooze_timer <= r_snooze_timer - 9'd1;
            end

            if (w_clear_cnt) begin
                r_snooze_cnt <= 2'd0;
            end else if (w_snooze_start) begin
                r_snooze_cnt <= r_snooze_cnt + 2'd1;
            end
        end
    end

    // Simultaneous inc and dec cancel each other
    assign w_edit_inc = set_mode & w_inc_p & ~w_dec_p;
    assign w_edit_dec = set_mode & w_dec_p & ~w_inc_p;

    // Alarm time editing in set mode, independent of the alarm state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm_h   <= 6'd0;
            r_alarm_m   <= 6'd0;
            r_field_sel <= 1'b0;
        end else begin
            if (set_mode && w_sel_p) r_field_sel <= ~r_field_sel;
            if (r_field_sel) begin
                if (w_edit_inc)      r_alarm_h <= (r_alarm_h >= 6'd23) ? 6'd0  : r_alarm_h + 6'd1;
                else if (w_edit_dec) r_alarm_h <= (r_alarm_h == 6'd0)  ? 6'd23 : r_alarm_h - 6'd1;
            end else begin
                if (w_edit_inc)      r_alarm_m <= (r_alarm_m >= 6'd59) ? 6'd0  : r_alarm_m + 6'd1;
                else if (w_edit_dec) r_alarm_m <= (r_alarm_m == 6'd0)  ? 6'd59 : r_alarm_m - 6'd1;
            end
        end
    end

    assign alarm_h    = r_alarm_h;
    assign alarm_m    = r_alarm_m;
    assign field_sel  = r_field_sel;
    assign armed      = r_armed;
    assign ringing    = r_ringing;
    assign snoozing   = r_snoozing;
    assign buzzer     = r_buzzer;
    assign snooze_cnt = r_snooze_cnt;

endmodule
